// File: rtl/half_torus_traffic_gen_pkg.sv
// Shared types and helpers for the half-torus traffic generator: FSM states,
// LFSR feedback taps, payload layout and saturating counter increment.
package half_torus_traffic_gen_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
  localparam logic [15:0] lfsr_taps_c = 16'hB400;

  localparam int coord_max_width_c = 16;

  typedef struct packed {
    logic [coord_max_width_c-1:0] y;
    logic [coord_max_width_c-1:0] x;
    logic [15:0]                  seq;
  } payload_s;

  // Lays out {y, x, seq} with x occupying exactly x_width bits above seq.
  function automatic logic [47:0] pack_payload(input payload_s p, input int x_width);
    return ({32'b0, p.y} << (16 + x_width)) | ({32'b0, p.x} << 16) | {32'b0, p.seq};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/half_torus_traffic_gen_lfsr.sv
// 16-bit Fibonacci LFSR that advances only while en_i is high; loads seed_i on reset.
module half_torus_traffic_gen_lfsr
  import half_torus_traffic_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & lfsr_taps_c)};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= seed_i;
    else            lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/half_torus_traffic_gen.sv
// Half-torus link traffic generator: LFSR-paced packet injection with statistics.
// Optional macro HALF_TORUS_TRAFFIC_GEN_BACKPRESSURE_EN randomises our ready_and_rev.
module half_torus_traffic_gen
  import half_torus_traffic_gen_pkg::*;
#(
  parameter int          width_p        = 32,
  parameter int          x_cord_width_p = 4,
  parameter int          y_cord_width_p = 4,
  parameter logic [15:0] seed_p         = 16'h0001,
  parameter int          drain_cycles_p = 64,
  localparam int         link_width_lp  = width_p + 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [link_width_lp-1:0]  link_i,
  output logic [link_width_lp-1:0]  link_o,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      start_i,
  input  logic [31:0]               num_pkts_i,
  input  logic [7:0]                rate_i,
  output logic                      done_o,
  output logic [31:0]               sent_o,
  output logic [31:0]               recv_o,
  output logic [31:0]               stall_o
);

  localparam logic [15:0] seed_lp = (seed_p == 16'h0000) ? 16'h0001 : seed_p;

  state_e               state_q, state_d;
  logic                 v_q, v_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [31:0]          num_q, num_d, sent_q, sent_d, recv_q, recv_d;
  logic [31:0]          stall_q, stall_d, drain_q, drain_d;
  logic                 rdy_en_q;
  logic [15:0]          lfsr;
  logic                 in_v, far_rdy, our_rdy, hs, rx_en, create;
  logic [31:0]          sent_after;
  payload_s             pl;
  logic                 unused_rx_data, unused_lfsr;

  assign in_v           = link_i[link_width_lp-1];
  assign far_rdy        = link_i[0];
  assign unused_rx_data = ^link_i[width_p:1];
  assign unused_lfsr    = ^lfsr;
  assign hs             = v_q & far_rdy;
  assign rx_en          = (state_q == RUN) || (state_q == DRAIN);

`ifdef HALF_TORUS_TRAFFIC_GEN_BACKPRESSURE_EN
  assign our_rdy = rdy_en_q & (rx_en ? lfsr[15] : 1'b1);
`else
  assign our_rdy = rdy_en_q;
`endif

  half_torus_traffic_gen_lfsr u_lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (state_q == RUN),
    .seed_i    (seed_lp),
    .lfsr_o    (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    data_d     = data_q;
    num_d      = num_q;
    sent_d     = sent_q;
    stall_d    = stall_q;
    drain_d    = drain_q;
    recv_d     = sat_inc(recv_q, rx_en & in_v & our_rdy);
    create     = 1'b0;
    // seq of a newly created packet reflects any handshake completing this cycle
    sent_after = sent_q + {31'b0, hs};
    pl         = '0;
    pl.y       = coord_max_width_c'(my_y_i);
    pl.x       = coord_max_width_c'(my_x_i);
    pl.seq     = sent_after[15:0];

    case (state_q)
      IDLE: begin
        if (start_i && (num_pkts_i != 32'd0)) begin
          state_d = RUN;
          num_d   = num_pkts_i;
          sent_d  = '0;
          recv_d  = '0;
          stall_d = '0;
        end
      end
      RUN: begin
        sent_d  = sat_inc(sent_q, hs);
        stall_d = sat_inc(stall_q, v_q & ~far_rdy);
        create  = (!v_q || hs) && (sent_after < num_q) &&
                  ((lfsr[7:0] < rate_i) || (rate_i == 8'hFF));
        if (hs) v_d = 1'b0;
        if (create) begin
          v_d    = 1'b1;
          data_d = width_p'(pack_payload(pl, x_cord_width_p));
        end
        if (hs && (sent_after == num_q)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == 32'(drain_cycles_p - 1)) state_d = DONE;
        else                                    drain_d = drain_q + 32'd1;
      end
      DONE: begin
        if (!start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      v_q      <= 1'b0;
      data_q   <= '0;
      num_q    <= '0;
      sent_q   <= '0;
      recv_q   <= '0;
      stall_q  <= '0;
      drain_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      data_q   <= data_d;
      num_q    <= num_d;
      sent_q   <= sent_d;
      recv_q   <= recv_d;
      stall_q  <= stall_d;
      drain_q  <= drain_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign link_o  = {v_q, data_q, our_rdy};
  assign done_o  = (state_q == DONE);
  assign sent_o  = sent_q;
  assign recv_o  = recv_q;
  assign stall_o = stall_q;

endmodule

// File: tb/tb_half_torus_traffic_gen.sv
// Self-checking bench for half_torus_traffic_gen: directed scenarios plus
// randomized runs checked against a transaction-level reference model.
module tb_half_torus_traffic_gen;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int W  = 32;
  localparam int DRAIN_N = 64;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk_i, reset_n_i, start_i, in_v, far_rdy, done_o;
  logic [W-1:0]  in_data;
  logic [31:0]   num_pkts_i, sent_o, recv_o, stall_o;
  logic [7:0]    rate_i;
  logic [XW-1:0] my_x_i;
  logic [YW-1:0] my_y_i;
  logic [W+1:0]  link_i, link_o;
  logic          v_o, our_rdy_o;
  logic [W-1:0]  data_o;

  assign link_i    = {in_v, in_data, far_rdy};
  assign v_o       = link_o[W+1];
  assign data_o    = link_o[W:1];
  assign our_rdy_o = link_o[0];

  half_torus_traffic_gen #(
    .width_p(W), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .seed_p(16'h0001), .drain_cycles_p(DRAIN_N)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .link_i(link_i), .link_o(link_o),
    .my_x_i(my_x_i), .my_y_i(my_y_i), .start_i(start_i), .num_pkts_i(num_pkts_i),
    .rate_i(rate_i), .done_o(done_o), .sent_o(sent_o), .recv_o(recv_o), .stall_o(stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          m_st;
  logic        m_v, m_rdy_en;
  logic [31:0] m_data;
  logic [15:0] m_lfsr;
  int unsigned m_num, m_sent, m_recv, m_stall, m_dcnt;

  // bookkeeping for directed checks
  int cyc = 0, cur_run = 0, max_run = 0, last_hs_cyc = -1, done_cyc = -1;
  int fr_mode = 0, rx_mode = 0, stall_n = 0;
  logic [15:0] seq_q[$];

  function automatic logic [31:0] pkt_word(input logic [3:0] y, input logic [3:0] x, input int unsigned seq);
    return (32'(y) * 32'h0010_0000) + (32'(x) * 32'h0001_0000) + (seq % 65536);
  endfunction

  // polynomial x^16+x^14+x^13+x^11+1: feedback from terms 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int unsigned v, fb;
    v  = 32'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic logic model_our_rdy();
`ifdef HALF_TORUS_TRAFFIC_GEN_BACKPRESSURE_EN
    if (m_st == M_RUN || m_st == M_DRAIN) return m_rdy_en & m_lfsr[15];
`endif
    return m_rdy_en;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_v = 1'b0; m_data = '0; m_lfsr = 16'h0001; m_rdy_en = 1'b0;
    m_num = 0; m_sent = 0; m_recv = 0; m_stall = 0; m_dcnt = 0;
  endtask

  task automatic model_edge();
    logic hs, ordy, mk;
    if (!reset_n_i) begin
      model_reset();
      return;
    end
    hs   = m_v && far_rdy;
    ordy = model_our_rdy();
    case (m_st)
      M_IDLE: if (start_i && num_pkts_i != 0) begin
        m_st = M_RUN; m_num = num_pkts_i; m_sent = 0; m_recv = 0; m_stall = 0;
      end
      M_RUN: begin
        if (m_v && !far_rdy) m_stall++;
        if (in_v && ordy) m_recv++;
        if (hs) begin m_sent++; m_v = 1'b0; end
        mk = !m_v && (m_sent < m_num) && ((m_lfsr[7:0] < rate_i) || rate_i == 8'hFF);
        if (mk) begin m_v = 1'b1; m_data = pkt_word(my_y_i, my_x_i, m_sent); end
        if (hs && m_sent == m_num) begin m_st = M_DRAIN; m_dcnt = 0; end
        m_lfsr = lfsr_next(m_lfsr);
      end
      M_DRAIN: begin
        if (in_v && ordy) m_recv++;
        m_dcnt++;
        if (m_dcnt == DRAIN_N) m_st = M_DONE;
      end
      default: if (!start_i) m_st = M_IDLE;
    endcase
    m_rdy_en = 1'b1;
  endtask

  task automatic tick();
    if (v_o && far_rdy) begin
      seq_q.push_back(data_o[15:0]);
      last_hs_cyc = cyc;
    end
    @(posedge clk_i);
    model_edge();
    #1;
    cyc++;
    if (done_o && done_cyc < 0) done_cyc = cyc;
    cur_run = v_o ? cur_run + 1 : 0;
    if (cur_run > max_run) max_run = cur_run;
    chk("v", 64'(v_o), 64'(m_v));
    if (m_v) chk("data", 64'(data_o), 64'(m_data));
    chk("done", 64'(done_o), 64'(m_st == M_DONE));
    chk("our_rdy", 64'(our_rdy_o), 64'(model_our_rdy()));
    chk("sent", 64'(sent_o), 64'(m_sent));
    chk("recv", 64'(recv_o), 64'(m_recv));
    chk("stall", 64'(stall_o), 64'(m_stall));
  endtask

  task automatic pick_inputs();
    case (fr_mode)
      0: far_rdy = 1'b1;
      1: if (m_v && m_data[15:0] == 16'd2 && stall_n < 3) begin
           chk("stall_hold_data", 64'(data_o), 64'(pkt_word(my_y_i, my_x_i, 2)));
           far_rdy = 1'b0;
           stall_n++;
         end else far_rdy = 1'b1;
      default: far_rdy = ($urandom_range(0, 3) != 0);
    endcase
    in_v    = (rx_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data = $urandom;
  endtask

  task automatic start_run(input int unsigned num, input logic [7:0] rate);
    seq_q.delete();
    max_run = 0; cur_run = 0; last_hs_cyc = -1; done_cyc = -1; stall_n = 0;
    num_pkts_i = num; rate_i = rate; start_i = 1'b1;
    pick_inputs();
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      pick_inputs();
      tick();
      n++;
    end
    chk("run_reached_done", 64'(done_o), 64'd1);
    in_v = 1'b0;
    far_rdy = 1'b1;
    tick();
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; in_v = 1'b0; far_rdy = 1'b1; in_data = '0;
    num_pkts_i = '0; rate_i = '0; my_x_i = 4'h3; my_y_i = 4'h5;
    model_reset();
    #3;
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rdy", 64'(our_rdy_o), 64'd0);
    chk("rst_cnt", 64'(sent_o | recv_o | stall_o), 64'd0);
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    chk("rdy_after_release", 64'(our_rdy_o), 64'd1);

    // start with zero packets stays idle
    num_pkts_i = 0; start_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("zero_pkts_v", 64'(v_o), 64'd0);
    chk("zero_pkts_done", 64'(done_o), 64'd0);
    start_i = 1'b0;
    tick();

    // full rate, always ready: 10 back-to-back packets
    fr_mode = 0; rx_mode = 0;
    start_run(10, 8'hFF);
    run_to_done(400);
    chk("ff_consec_v", 64'(max_run), 64'd10);
    chk("ff_seq_count", 64'(seq_q.size()), 64'd10);
    for (int i = 0; i < seq_q.size(); i++) chk("ff_seq", 64'(seq_q[i]), 64'(i));
    chk("ff_sent", 64'(sent_o), 64'd10);
    chk("ff_stall", 64'(stall_o), 64'd0);
    chk("ff_drain_len", 64'(done_cyc - last_hs_cyc - 1), 64'(DRAIN_N));

    // far end stalls packet 2 for 3 cycles
    fr_mode = 1; rx_mode = 0; my_x_i = 4'hA; my_y_i = 4'h6;
    start_run(4, 8'hFF);
    run_to_done(400);
    chk("bp_stall_cnt", 64'(stall_o), 64'd3);
    chk("bp_sent", 64'(sent_o), 64'd4);

    // incoming traffic: 7 during RUN+DRAIN, 2 after DONE
    fr_mode = 0; rx_mode = 0;
    start_run(3, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      far_rdy = 1'b1;
      in_v = (i < 14) && (i % 2 == 0);
      in_data = $urandom;
      tick();
    end
    in_v = 1'b0;
    run_to_done(400);
    in_v = 1'b1;
    tick(); tick();
    in_v = 1'b0;
    tick();
`ifndef HALF_TORUS_TRAFFIC_GEN_BACKPRESSURE_EN
    chk("rx_recv7", 64'(recv_o), 64'd7);
`endif

    // reset in the middle of a run
    fr_mode = 0; rx_mode = 0;
    start_run(20, 8'hFF);
    for (int n = 0; n < 100 && sent_o != 32'd5; n++) begin
      pick_inputs();
      tick();
    end
    chk("mid_sent5", 64'(sent_o), 64'd5);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", 64'(v_o), 64'd0);
    chk("mid_rst_sent", 64'(sent_o), 64'd0);
    chk("mid_rst_stall", 64'(stall_o), 64'd0);
    chk("mid_rst_recv", 64'(recv_o), 64'd0);
    model_reset();
    tick();
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_idle_v", 64'(v_o), 64'd0);
    chk("post_rst_idle_done", 64'(done_o), 64'd0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      fr_mode = 2; rx_mode = 1;
      my_x_i = 4'($urandom); my_y_i = 4'($urandom);
      start_run($urandom_range(1, 25), 8'($urandom_range(32, 255)));
      run_to_done(3000);
      $display("[TB] random run %0d: sent=%0d recv=%0d stall=%0d", r, sent_o, recv_o, stall_o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
